wbvio_arbiter: RTL and testbench
================================

Name: wbvio_arbiter

Overview:
- Two-master Wishbone arbiter sitting directly downstream of the VIO debug bridge master port.
- Master 0 is the VIO/ChipScope debug master; master 1 is the primary host master (PCI/TURF path).
- Single Wishbone master port toward the SURF4 slave interconnect.
- Round-robin arbitration with a bus-hang watchdog, so a dead slave cannot wedge debug access.

Parameters:
- TIMEOUT, 1024: cycles an owner may hold STB without ACK/ERR/RTY before an abort; legal 2..65535.
- ADR_W, 20: address width.
- DAT_W, 32: data width (SEL width = DAT_W/8).

Ports:
- clk_i, in, 1: Wishbone clock (wbc_clk); sole clock.
- rst_i, in, 1: synchronous, active-low reset.
- m0_cyc_i, m0_stb_i, m0_we_i, in, 1 each: master 0 control.
- m0_adr_i / m0_dat_i / m0_sel_i, in, ADR_W / DAT_W / 4: master 0 address, write data, byte select.
- m0_dat_o, out, DAT_W: read data to master 0.
- m0_ack_o, m0_err_o, m0_rty_o, out, 1 each: cycle termination to master 0.
- m1_* (same set as m0_*): master 1, identical directions and widths.
- s_cyc_o, s_stb_o, s_we_o, out, 1 each: slave-side control.
- s_adr_o / s_dat_o / s_sel_o, out, ADR_W / DAT_W / 4: slave-side address, write data, byte select.
- s_dat_i, s_ack_i, s_err_i, s_rty_i, in, DAT_W / 1 / 1 / 1: slave response.
- grant_o, out, 2: one-hot current owner (bit0 = m0); 00 when idle.
- timeout_cnt_o, out, 8: saturating count of watchdog aborts.

Behaviour:
- FSM states:
  - IDLE: no owner.
  - OWN: owner's signals routed to the slave.
  - ABORT: one cycle.
  - DRAIN: wait for the owner to release.
- Reset (rst_i = 0 at a clock edge), effective the same edge, including mid-transfer:
  - state = IDLE, grant_o = 00, last = 1 (so m0 wins the first contention), watchdog counter = 0, timeout_cnt_o = 0.
  - All slave and master outputs are 0.
- IDLE transitions:
  - Only one mK_cyc_i high: grant K and go to OWN next edge.
  - Both high: grant the master opposite to last.
  - Arbitration latency is 1 cycle. A request is never routed in the cycle it is first seen.
- OWN routing and termination:
  - s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o and s_sel_o are combinational copies of the owner's inputs.
  - s_ack_i, s_err_i, s_rty_i and s_dat_i route only to the owner.
  - The non-owner sees ack/err/rty = 0; its dat_o is don't-care, driven 0.
- OWN, owner drops cyc: go to IDLE next edge, last = owner, grant_o = 00. The bus is re-arbitrated from IDLE; there is no back-to-back handover.
- Owner cyc high across multiple STB phases: ownership is retained, so block and RMW transfers are atomic.
- Watchdog counter:
  - Increments each OWN cycle with s_stb_o = 1 and s_ack_i | s_err_i | s_rty_i = 0.
  - Clears on any termination and whenever the owner's stb is low.
  - Reaching TIMEOUT-1 with no termination that cycle: go to ABORT.
- ABORT:
  - s_cyc_o = s_stb_o = 0.
  - Owner receives err_o = 1 for exactly 1 cycle.
  - timeout_cnt_o increments, saturating at 255.
  - Next state is DRAIN.
- DRAIN:
  - s_cyc_o = 0 and the owner's ack/err/rty = 0.
  - grant_o is held.
  - Owner cyc low: go to IDLE, last = owner.
- Slave termination in the same cycle the counter hits TIMEOUT-1: the termination wins. No abort; the counter clears.
- Stray s_ack_i in IDLE/ABORT/DRAIN: ignored, not forwarded.
- Pipelining: no registered path master→slave or slave→master while in OWN. The only added latency is the 1-cycle grant.

Decomposition:
- Shared package wbvio_pkg: FSM state encoding (IDLE/OWN/ABORT/DRAIN) and a GRANT_M0 / GRANT_M1 / GRANT_NONE constant set.
- One natural sub-module, wbvio_watchdog:
  - Inputs: clk_i, rst_i, en (OWN & stb), term.
  - Output: a one-cycle expire pulse.
  - Internal counter of width $clog2(TIMEOUT).
- Muxing and the FSM stay in wbvio_arbiter.

Test Plan:
- Single m0 read, adr 0x00010, slave acks 2 cycles after s_stb_o → grant_o=01 one cycle after m0_cyc_i, m0_dat_o=s_dat_i=0xDEADBEEF with m0_ack_o=1, grant_o=00 the cycle after m0_cyc_i drops.
- After reset, m0 and m1 raise cyc in the same cycle, each does one write then releases and re-requests → grants alternate m0, m1, m0, m1; no cycle with both granted; m1_ack_o=0 throughout m0 ownership.
- m1 holds cyc over 3 STB phases while m0 requests → m0 not granted until m1_cyc_i falls; m0 is then granted 2 cycles after m1_cyc_i fell (1 to IDLE, 1 to grant).
- TIMEOUT=16, slave never acks m0 → s_cyc_o drops and m0_err_o=1 for exactly 1 cycle 16 cycles after s_stb_o rose; timeout_cnt_o=1; grant_o stays 01 until m0_cyc_i low.
- TIMEOUT=16, slave acks exactly on the 16th stalled cycle → normal ack to master, no err, timeout_cnt_o unchanged.
- rst_i=0 asserted mid-OWN with m1 owning → next edge grant_o=00, all s_* outputs 0, timeout_cnt_o=0; after release, contention grants m0 first.

Source files
------------

// File: rtl/wbvio_pkg.sv
// Shared types for the VIO/host Wishbone arbiter.
// FSM state encoding and one-hot grant constants.
package wbvio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OWN,
    ST_ABORT,
    ST_DRAIN
  } state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

endpackage

// File: rtl/wbvio_watchdog.sv
// Bus-hang watchdog: counts stalled strobe cycles.
// clk_i, rst_i (sync low), en, term in; expire one-cycle pulse out.
module wbvio_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en,
  input  logic term,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  // A termination in the final cycle wins over the abort.
  assign expire = en & ~term & (r_cnt == LAST);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_cnt <= '0;
    end else if (!en || term || expire) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/wbvio_arbiter.sv
// Two-master round-robin Wishbone arbiter with hang watchdog.
// m0 = VIO debug, m1 = host; s_* toward slave; grant_o, timeout_cnt_o.
module wbvio_arbiter
  import wbvio_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int ADR_W   = 20,
  parameter int DAT_W   = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               m0_cyc_i,
  input  logic               m0_stb_i,
  input  logic               m0_we_i,
  input  logic [ADR_W-1:0]   m0_adr_i,
  input  logic [DAT_W-1:0]   m0_dat_i,
  input  logic [DAT_W/8-1:0] m0_sel_i,
  output logic [DAT_W-1:0]   m0_dat_o,
  output logic               m0_ack_o,
  output logic               m0_err_o,
  output logic               m0_rty_o,
  input  logic               m1_cyc_i,
  input  logic               m1_stb_i,
  input  logic               m1_we_i,
  input  logic [ADR_W-1:0]   m1_adr_i,
  input  logic [DAT_W-1:0]   m1_dat_i,
  input  logic [DAT_W/8-1:0] m1_sel_i,
  output logic [DAT_W-1:0]   m1_dat_o,
  output logic               m1_ack_o,
  output logic               m1_err_o,
  output logic               m1_rty_o,
  output logic               s_cyc_o,
  output logic               s_stb_o,
  output logic               s_we_o,
  output logic [ADR_W-1:0]   s_adr_o,
  output logic [DAT_W-1:0]   s_dat_o,
  output logic [DAT_W/8-1:0] s_sel_o,
  input  logic [DAT_W-1:0]   s_dat_i,
  input  logic               s_ack_i,
  input  logic               s_err_i,
  input  logic               s_rty_i,
  output logic [1:0]         grant_o,
  output logic [7:0]         timeout_cnt_o
);

  state_t r_state, w_nxt;
  logic   r_owner, w_owner_nxt;
  logic   r_last, w_last_nxt;
  logic [7:0] r_tocnt;

  logic w_own, w_abort, w_term, w_en, w_expire;
  logic w_ocyc, w_ostb;
  logic w_r0, w_r1, w_a0, w_a1;

  assign w_own   = (r_state == ST_OWN);
  assign w_abort = (r_state == ST_ABORT);
  assign w_ocyc  = r_owner ? m1_cyc_i : m0_cyc_i;
  assign w_ostb  = r_owner ? m1_stb_i : m0_stb_i;
  assign w_term  = s_ack_i | s_err_i | s_rty_i;
  assign w_en    = w_own & w_ocyc & w_ostb;

  wbvio_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en     (w_en),
    .term   (w_term),
    .expire (w_expire)
  );

  always_comb begin
    w_nxt       = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    unique case (r_state)
      ST_IDLE: begin
        if (m0_cyc_i || m1_cyc_i) begin
          w_nxt = ST_OWN;
          // On contention the master that did not go last wins.
          w_owner_nxt = (m0_cyc_i && m1_cyc_i) ? ~r_last : m1_cyc_i;
        end
      end
      ST_OWN: begin
        if (!w_ocyc) begin
          w_nxt      = ST_IDLE;
          w_last_nxt = r_owner;
        end else if (w_expire) begin
          w_nxt = ST_ABORT;
        end
      end
      ST_ABORT: w_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (!w_ocyc) begin
          w_nxt      = ST_IDLE;
          w_last_nxt = r_owner;
        end
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_tocnt <= 8'd0;
    end else begin
      r_state <= w_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      if (w_abort && r_tocnt != 8'hFF) begin
        r_tocnt <= r_tocnt + 8'd1;
      end
    end
  end

  assign w_r0 = w_own & ~r_owner;
  assign w_r1 = w_own & r_owner;
  assign w_a0 = w_abort & ~r_owner;
  assign w_a1 = w_abort & r_owner;

  assign s_cyc_o = w_own & w_ocyc;
  assign s_stb_o = w_own & w_ostb;
  assign s_we_o  = w_own & (r_owner ? m1_we_i : m0_we_i);
  assign s_adr_o = w_own ? (r_owner ? m1_adr_i : m0_adr_i) : '0;
  assign s_dat_o = w_own ? (r_owner ? m1_dat_i : m0_dat_i) : '0;
  assign s_sel_o = w_own ? (r_owner ? m1_sel_i : m0_sel_i) : '0;

  assign m0_dat_o = w_r0 ? s_dat_i : '0;
  assign m0_ack_o = w_r0 & s_ack_i;
  assign m0_err_o = (w_r0 & s_err_i) | w_a0;
  assign m0_rty_o = w_r0 & s_rty_i;

  assign m1_dat_o = w_r1 ? s_dat_i : '0;
  assign m1_ack_o = w_r1 & s_ack_i;
  assign m1_err_o = (w_r1 & s_err_i) | w_a1;
  assign m1_rty_o = w_r1 & s_rty_i;

  assign grant_o = (r_state == ST_IDLE) ? GRANT_NONE :
                   (r_owner ? GRANT_M1 : GRANT_M0);
  assign timeout_cnt_o = r_tocnt;

endmodule

// File: tb/tb_wbvio_arbiter.sv
// Bench for wbvio_arbiter: transaction-level model plus directed pins.
// Random masters/slave with a dead-slave mode to exercise the watchdog.
module tb_wbvio_arbiter;
  localparam int TO = 16;
  localparam int AW = 20;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i;
  logic [1:0]    cyc, stb, we;
  logic [AW-1:0] adr [2];
  logic [DW-1:0] mdat [2];
  logic [SW-1:0] sel [2];
  logic [DW-1:0] dat_o [2];
  logic [1:0]    ack_o, err_o, rty_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0] s_adr_o;
  logic [DW-1:0] s_dat_o, s_dat_i;
  logic [SW-1:0] s_sel_o;
  logic          s_ack_i, s_err_i, s_rty_i;
  logic [1:0]    grant_o;
  logic [7:0]    timeout_cnt_o;

  wbvio_arbiter #(.TIMEOUT(TO), .ADR_W(AW), .DAT_W(DW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]),
    .m0_adr_i(adr[0]), .m0_dat_i(mdat[0]), .m0_sel_i(sel[0]),
    .m0_dat_o(dat_o[0]), .m0_ack_o(ack_o[0]),
    .m0_err_o(err_o[0]), .m0_rty_o(rty_o[0]),
    .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]),
    .m1_adr_i(adr[1]), .m1_dat_i(mdat[1]), .m1_sel_i(sel[1]),
    .m1_dat_o(dat_o[1]), .m1_ack_o(ack_o[1]),
    .m1_err_o(err_o[1]), .m1_rty_o(rty_o[1]),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .grant_o(grant_o), .timeout_cnt_o(timeout_cnt_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t",
                 name, act, exp, $time);
    end
  endtask

  // Model: who owns the bus, whether it is being aborted or drained,
  // how many consecutive stalled strobes have elapsed, abort tally.
  int mo_own = -1;
  bit mo_abort = 0, mo_drain = 0, mo_ok = 0;
  int mo_stall = 0, mo_last = 1, mo_to = 0;

  always @(posedge clk) begin
    if (!rst_i) begin
      mo_own <= -1; mo_abort <= 0; mo_drain <= 0;
      mo_stall <= 0; mo_last <= 1; mo_to <= 0; mo_ok <= 1;
    end else if (mo_own < 0) begin
      mo_stall <= 0;
      if (cyc[0] && cyc[1]) mo_own <= 1 - mo_last;
      else if (cyc[0]) mo_own <= 0;
      else if (cyc[1]) mo_own <= 1;
    end else if (mo_abort) begin
      mo_abort <= 0;
      mo_drain <= 1;
      mo_to <= (mo_to < 255) ? mo_to + 1 : 255;
    end else if (mo_drain) begin
      if (!cyc[mo_own]) begin
        mo_own <= -1; mo_drain <= 0; mo_last <= mo_own;
      end
    end else begin
      if (!cyc[mo_own]) begin
        mo_own <= -1; mo_last <= mo_own; mo_stall <= 0;
      end else if (stb[mo_own] && !(s_ack_i || s_err_i || s_rty_i)) begin
        if (mo_stall + 1 == TO) begin
          mo_abort <= 1; mo_stall <= 0;
        end else begin
          mo_stall <= mo_stall + 1;
        end
      end else begin
        mo_stall <= 0;
      end
    end
  end

  always @(negedge clk) begin : cmp
    logic [58:0] es;
    logic [1:0] eg;
    bit route;
    int k;
    if (mo_ok) begin
      route = (mo_own >= 0) && !mo_abort && !mo_drain;
      k = (mo_own == 1) ? 1 : 0;
      es = route ? {cyc[k], stb[k], we[k], adr[k], mdat[k], sel[k]} : '0;
      eg = (mo_own < 0) ? 2'b00 : ((mo_own == 0) ? 2'b01 : 2'b10);
      chk("grant", grant_o, eg);
      chk("slave_side", {s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
          s_sel_o}, es);
      chk("tocnt", timeout_cnt_o, mo_to[7:0]);
      for (int m = 0; m < 2; m++) begin
        logic [34:0] em;
        bit mine;
        mine = route && (mo_own == m);
        em = {mine && s_ack_i,
              (mine && s_err_i) || (mo_abort && mo_own == m),
              mine && s_rty_i,
              mine ? s_dat_i : 32'h0};
        chk(m == 0 ? "m0_resp" : "m1_resp",
            {ack_o[m], err_o[m], rty_o[m], dat_o[m]}, em);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 0; cyc = 0; stb = 0; we = 0;
    s_ack_i = 0; s_err_i = 0; s_rty_i = 0;
    tick(); tick();
    rst_i = 1;
  endtask

  initial begin
    bit dead;
    bit found;
    rst_i = 0; cyc = 0; stb = 0; we = 0;
    s_ack_i = 0; s_err_i = 0; s_rty_i = 0; s_dat_i = 0;
    for (int m = 0; m < 2; m++) begin
      adr[m] = '0; mdat[m] = '0; sel[m] = '0;
    end
    do_reset();
    @(negedge clk);
    chk("reset_grant", grant_o, 2'b00);
    chk("reset_scyc", s_cyc_o, 1'b0);
    chk("reset_tocnt", timeout_cnt_o, 8'd0);

    // Single m0 read, slave acks two cycles after strobe.
    tick();
    cyc[0] = 1; stb[0] = 1; adr[0] = 20'h00010; sel[0] = 4'hF;
    tick();
    @(negedge clk);
    chk("rd_grant", grant_o, 2'b01);
    tick(); tick();
    s_ack_i = 1; s_dat_i = 32'hDEADBEEF;
    @(negedge clk);
    chk("rd_ack", ack_o[0], 1'b1);
    chk("rd_dat", dat_o[0], 32'hDEADBEEF);
    tick();
    s_ack_i = 0; cyc[0] = 0; stb[0] = 0;
    tick();
    @(negedge clk);
    chk("rd_release", grant_o, 2'b00);

    // Contention: grants alternate starting with m0.
    do_reset();
    cyc = 2'b11; stb = 2'b11; we = 2'b11;
    for (int i = 0; i < 4; i++) begin
      int o;
      found = 0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (grant_o != 2'b00) begin
          found = 1;
          break;
        end
        tick();
      end
      chk("alt_found", found, 1'b1);
      chk("alt_grant", grant_o, (i % 2 == 0) ? 2'b01 : 2'b10);
      o = (i % 2 == 0) ? 0 : 1;
      tick();
      s_ack_i = 1;
      @(negedge clk);
      chk("alt_other_ack", ack_o[1-o], 1'b0);
      tick();
      s_ack_i = 0; cyc[o] = 0; stb[o] = 0;
      tick();
      cyc[o] = 1; stb[o] = 1;
    end

    // m1 keeps cyc over three strobe phases; m0 waits.
    do_reset();
    cyc[1] = 1; stb[1] = 1;
    tick();
    cyc[0] = 1; stb[0] = 1;
    for (int p = 0; p < 3; p++) begin
      tick();
      s_ack_i = 1;
      @(negedge clk);
      chk("hold_grant", grant_o, 2'b10);
      tick();
      s_ack_i = 0; stb[1] = 0;
      tick();
      stb[1] = 1;
    end
    tick();
    cyc[1] = 0; stb[1] = 0;
    @(negedge clk);
    chk("hold_last", grant_o, 2'b10);
    tick();
    @(negedge clk);
    chk("hold_idle", grant_o, 2'b00);
    tick();
    @(negedge clk);
    chk("hold_m0", grant_o, 2'b01);

    // Dead slave: abort 16 cycles after strobe rose.
    do_reset();
    cyc[0] = 1; stb[0] = 1;
    tick();
    repeat (16) tick();
    @(negedge clk);
    chk("to_err", err_o[0], 1'b1);
    chk("to_scyc", s_cyc_o, 1'b0);
    tick();
    @(negedge clk);
    chk("to_err_once", err_o[0], 1'b0);
    chk("to_cnt", timeout_cnt_o, 8'd1);
    chk("to_hold", grant_o, 2'b01);
    tick();
    cyc[0] = 0; stb[0] = 0;
    tick();
    @(negedge clk);
    chk("to_release", grant_o, 2'b00);

    // Ack on the 16th stalled cycle beats the abort.
    do_reset();
    cyc[0] = 1; stb[0] = 1;
    tick();
    repeat (15) tick();
    s_ack_i = 1;
    @(negedge clk);
    chk("edge_ack", ack_o[0], 1'b1);
    chk("edge_noerr", err_o[0], 1'b0);
    tick();
    s_ack_i = 0;
    @(negedge clk);
    chk("edge_noabort", err_o[0], 1'b0);
    chk("edge_cnt", timeout_cnt_o, 8'd0);
    tick();
    cyc[0] = 0; stb[0] = 0;
    tick();

    // Reset while m1 owns, then contention goes to m0.
    do_reset();
    cyc[1] = 1; stb[1] = 1;
    tick(); tick();
    rst_i = 0;
    tick();
    @(negedge clk);
    chk("rst_grant", grant_o, 2'b00);
    chk("rst_scyc", {s_cyc_o, s_stb_o, s_adr_o}, '0);
    chk("rst_cnt", timeout_cnt_o, 8'd0);
    tick();
    rst_i = 1; cyc = 2'b11; stb = 2'b11;
    tick();
    @(negedge clk);
    chk("rst_m0_first", grant_o, 2'b01);

    // Randomized traffic against the model.
    do_reset();
    dead = 0;
    repeat (4000) begin
      tick();
      rst_i = ($urandom_range(0, 499) != 0);
      for (int m = 0; m < 2; m++) begin
        if (cyc[m]) begin
          if ($urandom_range(0, 31) == 0) cyc[m] = 0;
        end else if ($urandom_range(0, 3) == 0) begin
          cyc[m] = 1;
        end
        stb[m] = cyc[m] & ($urandom_range(0, 15) != 0);
        we[m] = $urandom_range(0, 1);
        adr[m] = AW'($urandom);
        mdat[m] = $urandom;
        sel[m] = SW'($urandom);
      end
      if ($urandom_range(0, 63) == 0) dead = !dead;
      s_ack_i = !dead && ($urandom_range(0, 2) == 0);
      s_err_i = !dead && ($urandom_range(0, 15) == 0);
      s_rty_i = !dead && ($urandom_range(0, 15) == 0);
      s_dat_i = $urandom;
    end
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
